ecc_scalar_mult_sequencer: RTL and testbench
============================================

Name: ecc_scalar_mult_sequencer

Overview:
Initiator-side controller for scalar multiplication Q = k·P over a prime field.
Walks the scalar MSB-first (left-to-right double-and-add) and issues requests to the point-doubling and point-addition engines over a start/done handshake.
Holds the accumulator point and resolves the special cases the engines cannot handle: point at infinity, equal operands, and inverse operands.
Sits between the top-level ECC core and the arithmetic engines.

Parameters:
N, 231, field element width (bits of p, x, y)
K, 231, scalar width
TIMEOUT, 65535, max cycles to wait for an engine done (used only with SMUL_TIMEOUT_EN)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  request pulse; k, px, py sampled when accepted
k  in  K  scalar
px, py  in  N  base point P (affine, never infinity)
busy  out  1  high from the accepting cycle until the cycle before done
done  out  1  one-cycle completion pulse
qx, qy  out  N  result point; valid when done=1, held until next accepted start
q_inf  out  1  result is point at infinity
err  out  1  timeout abort flag (constant 0 without the macro)
dbl_start  out  1  one-cycle doubling request
dbl_x, dbl_y  out  N  doubling operand
dbl_done  in  1  doubling result valid (one-cycle pulse)
dbl_x3, dbl_y3  in  N  doubling result
dbl_inf  in  1  doubling result is infinity
add_start  out  1  one-cycle addition request
add_x1, add_y1, add_x2, add_y2  out  N  addition operands (Q, P)
add_done  in  1  addition result valid (one-cycle pulse)
add_x3, add_y3  in  N  addition result
add_inf  in  1  addition result is infinity

Behaviour:
- Reset (clk=1, reset=1): state IDLE; all outputs 0, including qx, qy, q_inf, busy, done, err, dbl_start, add_start.
- Reset mid-operation: the operation is abandoned with no done pulse. A late dbl_done or add_done arriving after reset is ignored.
- IDLE: start=1 latches k, px, py; sets Q := infinity; goes to SCAN. start is ignored in every other state.
- SCAN (1 cycle): a leading-one encoder finds the MSB index m of k.
  - k = 0: go to FIN with q_inf=1, qx=qy=0.
  - Otherwise: Q := P; idx := m. If m = 0, go to FIN; else go to NEXT.
- NEXT: idx := idx-1; go to DBL_REQ.
- DBL_REQ: if Q is infinity, Q stays infinity and no request is issued. Otherwise pulse dbl_start with dbl_x/y = Q; go to DBL_WAIT.
- Operand stability: dbl_x/y and add_* are held stable from the start pulse until the matching done.
- DBL_WAIT: on dbl_done, Q := (dbl_x3, dbl_y3, dbl_inf). Then go to ADD_CHK if k[idx]=1; else go to NEXT if idx>0, otherwise FIN.
- ADD_CHK (1 cycle), first matching case:
  - Q infinity: Q := P.
  - Q.x = px and Q.y = py: go to DBL_REQ with Q (substitute doubling); its result is handled as the add result.
  - Q.x = px and Q.y ≠ py: Q := infinity, no request issued.
  - Otherwise: pulse add_start with (Q, P); go to ADD_WAIT.
- ADD_WAIT: on add_done, Q := result. Go to NEXT if idx>0, else FIN.
- A done pulse received in any state other than the matching WAIT state is ignored.
- FIN: drive qx, qy, q_inf from Q; done=1 for exactly one cycle; busy=0; return to IDLE. start is accepted the cycle after done.
- Operation count: exactly m doublings plus popcount(k[m-1:0]) additions/substitutions. Cycle count is engine latency plus at most 3 control cycles per bit.
- Width: Q registers are N bits plus 1 infinity bit. No arithmetic is done here beyond equality compares.

Optional Feature:
SMUL_TIMEOUT_EN
- Defined: a 16-bit counter clears on each dbl_start/add_start and increments in DBL_WAIT and ADD_WAIT. Reaching TIMEOUT forces FIN with err=1, q_inf=1, qx=qy=0. err holds until the next accepted start or reset.
- Undefined: no counter; err is tied 0; the WAIT states wait indefinitely.

Decomposition:
- Package ecc_pkg: state enum (IDLE, SCAN, NEXT, DBL_REQ, DBL_WAIT, ADD_CHK, ADD_WAIT, FIN), default N, and a point struct {x, y, inf}.
- Sub-module ecc_leading_one: combinational priority encoder, K-bit in, clog2(K)-bit index plus zero flag out.

Test Plan:
The bench uses behavioural dbl/add engines with 5-cycle latency. Curve y²=x³+2x+2 mod 17, P=(5,1), order 19.
- k=0 -> done within 3 cycles, q_inf=1, zero dbl_start/add_start pulses.
- k=1 -> Q=(5,1), q_inf=0, no engine requests.
- k=9 -> Q=(7,6); 3 dbl_start and 1 add_start pulses.
- k=19 -> q_inf=1; the final add is resolved as inverse (18P=(5,16)) with no add_start issued; 4 dbl and 1 add total.
- k=21 -> Q=(6,3); in ADD_CHK, 20P=P triggers the substitute doubling; verify dbl_x/y=(5,1) on that request.
- Reset asserted 2 cycles into DBL_WAIT for k=9, then a stray dbl_done -> outputs stay 0, no done. A new start with k=2 -> (6,3).
- Under SMUL_TIMEOUT_EN with TIMEOUT=20 and an engine that never answers -> done at cycle ~22, err=1, q_inf=1.

Source files
------------

// File: rtl/ecc_pkg.sv
// Shared types for the ECC scalar-multiplication sequencer: FSM states and the
// affine point with an explicit infinity flag.
package ecc_pkg;

   localparam int ECC_N = 231;

   typedef enum logic [2:0] {
      IDLE, SCAN, NEXT, DBL_REQ, DBL_WAIT, ADD_CHK, ADD_WAIT, FIN
   } state_t;

   typedef struct packed {
      logic [ECC_N-1:0] x;
      logic [ECC_N-1:0] y;
      logic             inf;
   } point_t;

   localparam point_t PT_INF = '{x: '0, y: '0, inf: 1'b1};

endpackage

// File: rtl/ecc_leading_one.sv
// Combinational leading-one encoder: index of the highest set bit, plus a zero flag.
module ecc_leading_one #(
   parameter int K  = 231,
   parameter int IW = (K > 1) ? $clog2(K) : 1
) (
   input  logic [K-1:0]  vec_i,
   output logic [IW-1:0] idx_o,
   output logic          zero_o
);

   always_comb begin
      idx_o = '0;
      for (int i = 0; i < K; i++)
         if (vec_i[i]) idx_o = IW'(i);
   end

   assign zero_o = ~|vec_i;

endmodule

// File: rtl/ecc_scalar_mult_sequencer.sv
// Left-to-right double-and-add controller driving external dbl/add engines.
// N must not exceed ecc_pkg::ECC_N. Optional engine timeout: SMUL_TIMEOUT_EN.
module ecc_scalar_mult_sequencer
   import ecc_pkg::*;
#(
   parameter int N       = ECC_N,
   parameter int K       = 231,
   parameter int TIMEOUT = 65535
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [K-1:0] k,
   input  logic [N-1:0] px,
   input  logic [N-1:0] py,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] qx,
   output logic [N-1:0] qy,
   output logic         q_inf,
   output logic         err,
   output logic         dbl_start,
   output logic [N-1:0] dbl_x,
   output logic [N-1:0] dbl_y,
   input  logic         dbl_done,
   input  logic [N-1:0] dbl_x3,
   input  logic [N-1:0] dbl_y3,
   input  logic         dbl_inf,
   output logic         add_start,
   output logic [N-1:0] add_x1,
   output logic [N-1:0] add_y1,
   output logic [N-1:0] add_x2,
   output logic [N-1:0] add_y2,
   input  logic         add_done,
   input  logic [N-1:0] add_x3,
   input  logic [N-1:0] add_y3,
   input  logic         add_inf
);

   localparam int IW = (K > 1) ? $clog2(K) : 1;

   state_t         state_q, state_d;
   point_t         q_q, q_d, p_pt;
   logic [K-1:0]   k_q;
   logic [N-1:0]   px_q, py_q;
   logic [IW-1:0]  idx_q, idx_d, lz_idx;
   logic           sub_q, sub_d, lz_zero;
   logic           dbl_go, add_go, tmo_hit;
   logic           busy_q, done_q, qinf_q, dbl_start_q, add_start_q;
   logic [N-1:0]   qx_q, qy_q;
   state_t         post_add, post_dbl;

   ecc_leading_one #(.K(K), .IW(IW)) u_lz (
      .vec_i  (k_q),
      .idx_o  (lz_idx),
      .zero_o (lz_zero)
   );

   assign p_pt     = '{x: ECC_N'(px_q), y: ECC_N'(py_q), inf: 1'b0};
   assign post_add = (idx_q == '0) ? FIN : NEXT;
   // A substitute doubling stands in for the add, so it never re-enters ADD_CHK.
   assign post_dbl = (k_q[idx_q] && !sub_q) ? ADD_CHK : post_add;

`ifdef SMUL_TIMEOUT_EN
   logic [15:0] tmo_q;
   logic        err_q;

   assign tmo_hit = ((state_q == DBL_WAIT && !dbl_done) || (state_q == ADD_WAIT && !add_done))
                    && (tmo_q == 16'(TIMEOUT - 1));
   assign err     = err_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         tmo_q <= '0;
         err_q <= 1'b0;
      end else begin
         if (dbl_go || add_go) tmo_q <= '0;
         else if (state_q == DBL_WAIT || state_q == ADD_WAIT) tmo_q <= tmo_q + 16'd1;
         if (state_q == IDLE && start) err_q <= 1'b0;
         else if (tmo_hit) err_q <= 1'b1;
      end
   end
`else
   assign tmo_hit = 1'b0;
   assign err     = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      idx_d   = idx_q;
      sub_d   = sub_q;
      dbl_go  = 1'b0;
      add_go  = 1'b0;
      case (state_q)
         IDLE: if (start) begin
            q_d     = PT_INF;
            sub_d   = 1'b0;
            state_d = SCAN;
         end
         SCAN: if (lz_zero) begin
            state_d = FIN;
         end else begin
            q_d     = p_pt;
            idx_d   = lz_idx;
            state_d = (lz_idx == '0) ? FIN : NEXT;
         end
         NEXT: begin
            idx_d   = idx_q - IW'(1);
            sub_d   = 1'b0;
            state_d = DBL_REQ;
         end
         DBL_REQ: if (q_q.inf) begin
            state_d = post_dbl;
         end else begin
            dbl_go  = 1'b1;
            state_d = DBL_WAIT;
         end
         DBL_WAIT: if (dbl_done) begin
            q_d     = '{x: ECC_N'(dbl_x3), y: ECC_N'(dbl_y3), inf: dbl_inf};
            state_d = post_dbl;
         end
         ADD_CHK: if (q_q.inf) begin
            q_d     = p_pt;
            state_d = post_add;
         end else if (q_q.x == p_pt.x && q_q.y == p_pt.y) begin
            sub_d   = 1'b1;
            state_d = DBL_REQ;
         end else if (q_q.x == p_pt.x) begin
            q_d     = PT_INF;
            state_d = post_add;
         end else begin
            add_go  = 1'b1;
            state_d = ADD_WAIT;
         end
         ADD_WAIT: if (add_done) begin
            q_d     = '{x: ECC_N'(add_x3), y: ECC_N'(add_y3), inf: add_inf};
            state_d = post_add;
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (tmo_hit) begin
         q_d     = PT_INF;
         state_d = FIN;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         q_q         <= '0;
         k_q         <= '0;
         px_q        <= '0;
         py_q        <= '0;
         idx_q       <= '0;
         sub_q       <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         qx_q        <= '0;
         qy_q        <= '0;
         qinf_q      <= 1'b0;
         dbl_start_q <= 1'b0;
         add_start_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         q_q         <= q_d;
         idx_q       <= idx_d;
         sub_q       <= sub_d;
         dbl_start_q <= dbl_go;
         add_start_q <= add_go;
         done_q      <= 1'b0;
         if (state_q == IDLE && start) begin
            k_q    <= k;
            px_q   <= px;
            py_q   <= py;
            busy_q <= 1'b1;
         end
         // Result and done are registered on FIN entry so done coincides with the FIN cycle.
         if (state_d == FIN && state_q != FIN) begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
            qx_q   <= q_d.x[N-1:0];
            qy_q   <= q_d.y[N-1:0];
            qinf_q <= q_d.inf;
         end
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign qx        = qx_q;
   assign qy        = qy_q;
   assign q_inf     = qinf_q;
   assign dbl_start = dbl_start_q;
   assign dbl_x     = q_q.x[N-1:0];
   assign dbl_y     = q_q.y[N-1:0];
   assign add_start = add_start_q;
   assign add_x1    = q_q.x[N-1:0];
   assign add_y1    = q_q.y[N-1:0];
   assign add_x2    = px_q;
   assign add_y2    = py_q;

endmodule

// File: tb/tb_ecc_scalar_mult_sequencer.sv
// Bench: curve y^2=x^3+2x+2 mod 17, P=(5,1), order 19; table-driven 5-cycle engines.
module tb_ecc_scalar_mult_sequencer;

   localparam int W = 231;
   localparam int TX[19] = '{0, 5, 6, 10, 3, 9, 16, 0, 13, 7, 7, 13, 0, 16, 9, 3, 10, 6, 5};
   localparam int TY[19] = '{0, 1, 3, 6, 1, 16, 13, 6, 7, 6, 11, 10, 11, 4, 1, 16, 11, 14, 16};

   logic         clk, reset, start;
   logic [W-1:0] k, px, py, qx, qy;
   logic         busy, done, q_inf, err;
   logic         dbl_start, dbl_done, dbl_inf, add_start, add_done, add_inf;
   logic [W-1:0] dbl_x, dbl_y, dbl_x3, dbl_y3;
   logic [W-1:0] add_x1, add_y1, add_x2, add_y2, add_x3, add_y3;

   int n_chk = 0, n_fail = 0;
   int n_dbl, n_add, dcnt, acnt, dres, ares;
   logic [W-1:0] dcap_x, dcap_y, last_dx, last_dy;
   logic eng_on, inject_dbl, in_op;
   int exp_mult, exp_nd, exp_na;
   logic exp_err;

   ecc_scalar_mult_sequencer #(.N(W), .K(W), .TIMEOUT(20)) dut (
      .clk(clk), .reset(reset), .start(start), .k(k), .px(px), .py(py),
      .busy(busy), .done(done), .qx(qx), .qy(qy), .q_inf(q_inf), .err(err),
      .dbl_start(dbl_start), .dbl_x(dbl_x), .dbl_y(dbl_y), .dbl_done(dbl_done),
      .dbl_x3(dbl_x3), .dbl_y3(dbl_y3), .dbl_inf(dbl_inf),
      .add_start(add_start), .add_x1(add_x1), .add_y1(add_y1), .add_x2(add_x2), .add_y2(add_y2),
      .add_done(add_done), .add_x3(add_x3), .add_y3(add_y3), .add_inf(add_inf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic int lookup(input logic [W-1:0] x, input logic [W-1:0] y);
      for (int j = 1; j < 19; j++)
         if (x == W'(TX[j]) && y == W'(TY[j])) return j;
      return -1;
   endfunction

   // Expected result as a multiple of P, plus engine request counts, from integer double-and-add.
   function automatic void model(input logic [W-1:0] kk, output int mult, output int nd, output int na);
      int m;
      mult = 0; nd = 0; na = 0; m = -1;
      for (int i = 0; i < W; i++) if (kk[i]) m = i;
      if (m < 0) return;
      mult = 1;
      for (int i = m - 1; i >= 0; i--) begin
         if (mult != 0) begin nd++; mult = (2 * mult) % 19; end
         if (kk[i]) begin
            if (mult == 0) mult = 1;
            else if (mult == 1) begin nd++; mult = 2; end
            else if (mult == 18) mult = 0;
            else begin na++; mult = mult + 1; end
         end
      end
   endfunction

   // Doubling engine
   initial begin
      dbl_done = 0; dbl_x3 = '0; dbl_y3 = '0; dbl_inf = 0; dcnt = 0; dres = 0;
      forever begin
         @(negedge clk);
         dbl_done = 0;
         if (reset) dcnt = 0;
         else begin
            if (inject_dbl) begin
               dbl_done = 1; dbl_x3 = W'(6); dbl_y3 = W'(3); inject_dbl = 0;
            end
            if (dcnt > 0) begin
               dcnt--;
               if (dcnt == 0) begin
                  chk("dbl_operand_stable", {dbl_x[115:0], dbl_y[114:0]}, {dcap_x[115:0], dcap_y[114:0]});
                  dbl_x3 = W'(TX[dres]); dbl_y3 = W'(TY[dres]); dbl_inf = (dres == 0);
                  dbl_done = 1;
               end
            end
            if (dbl_start) begin
               int j;
               n_dbl++; last_dx = dbl_x; last_dy = dbl_y;
               dcap_x = dbl_x; dcap_y = dbl_y;
               j = lookup(dbl_x, dbl_y);
               chk("dbl_operand_on_curve", W'(j > 0), W'(1));
               dres = (j > 0) ? (2 * j) % 19 : 0;
               if (eng_on) dcnt = 5;
            end
         end
      end
   end

   // Addition engine: rejects equal/inverse operands, which the sequencer must resolve itself.
   initial begin
      add_done = 0; add_x3 = '0; add_y3 = '0; add_inf = 0; acnt = 0; ares = 0;
      forever begin
         @(negedge clk);
         add_done = 0;
         if (reset) acnt = 0;
         else begin
            if (acnt > 0) begin
               acnt--;
               if (acnt == 0) begin
                  add_x3 = W'(TX[ares]); add_y3 = W'(TY[ares]); add_inf = (ares == 0);
                  add_done = 1;
               end
            end
            if (add_start) begin
               int i, j;
               n_add++;
               i = lookup(add_x1, add_y1);
               j = lookup(add_x2, add_y2);
               chk("add_operands_general", W'(i > 0 && j == 1 && i != 1 && i != 18), W'(1));
               ares = (i > 0 && j > 0) ? (i + j) % 19 : 0;
               if (eng_on) acnt = 5;
            end
         end
      end
   end

   // Per-cycle compare against the model while an operation is outstanding.
   initial begin
      forever begin
         @(negedge clk);
         if (in_op) begin
            if (done) begin
               chk("q_x", qx, W'(TX[exp_mult]));
               chk("q_y", qy, W'(TY[exp_mult]));
               chk("q_inf", W'(q_inf), W'(exp_mult == 0));
               chk("err", W'(err), W'(exp_err));
               chk("busy_at_done", W'(busy), W'(0));
               chk("dbl_requests", W'(n_dbl), W'(exp_nd));
               chk("add_requests", W'(n_add), W'(exp_na));
               in_op = 0;
            end else chk("busy_during_op", W'(busy), W'(1));
         end else if (!reset) chk("no_spurious_done", W'(done), W'(0));
         if (dbl_start && add_start) chk("one_request_at_a_time", W'(1), W'(0));
      end
   end

   task automatic launch(input logic [W-1:0] kk);
      model(kk, exp_mult, exp_nd, exp_na);
      exp_err = 0; n_dbl = 0; n_add = 0;
      @(posedge clk); #1 start = 1; k = kk;
      @(posedge clk); #1 start = 0; k = '0; in_op = 1;
   endtask

   task automatic wait_done(input int budget, output int cyc);
      cyc = 0;
      while (in_op && cyc < budget) begin @(posedge clk); cyc++; end
      #1;
      if (in_op) begin
         chk("done_within_budget", W'(in_op), W'(0));
         in_op = 0;
         reset = 1; repeat (2) @(posedge clk); #1 reset = 0;
      end
   endtask

   task automatic check_all_zero(input string nm);
      chk({nm, "_outputs"}, {qx[60:0], qy[60:0], dbl_x[50:0], add_x2[50:0], busy, done, q_inf, err,
                               dbl_start, add_start}, '0);
   endtask

   initial begin
      int cyc, mm, nd, na;
      reset = 1; start = 0; k = '0; px = W'(5); py = W'(1);
      eng_on = 1; inject_dbl = 0; in_op = 0; n_dbl = 0; n_add = 0;
      last_dx = '0; last_dy = '0; dcap_x = '0; dcap_y = '0; exp_err = 0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      @(posedge clk); #1 reset = 0;

      model(W'(9), mm, nd, na);
      chk("model_9P", W'({TX[mm], TY[mm], nd, na}), W'({32'd7, 32'd6, 32'd3, 32'd1}));
      model(W'(21), mm, nd, na);
      chk("model_21P", W'({TX[mm], TY[mm], nd, na}), W'({32'd6, 32'd3, 32'd5, 32'd1}));
      model(W'(19), mm, nd, na);
      chk("model_19P", W'({mm, nd, na}), W'({32'd0, 32'd4, 32'd1}));

      launch(W'(0));  wait_done(50, cyc);
      chk("k0_latency_le3", W'(cyc <= 3), W'(1));
      launch(W'(1));  wait_done(50, cyc);
      launch(W'(9));
      repeat (3) @(posedge clk);
      #1 start = 1; k = W'(1);
      @(posedge clk); #1 start = 0; k = '0;
      wait_done(500, cyc);
      launch(W'(19)); wait_done(500, cyc);
      launch(W'(21)); wait_done(500, cyc);
      chk("k21_subst_dbl_x", last_dx, W'(5));
      chk("k21_subst_dbl_y", last_dy, W'(1));
      launch(W'(38)); wait_done(500, cyc);
      launch(W'(7));  wait_done(500, cyc);
      launch(W'(20)); wait_done(500, cyc);
      launch({1'b1, {(W-2){1'b0}}, 1'b1}); wait_done(6000, cyc);

      // Abandon k=9 mid-doubling, then a stray dbl_done must be ignored.
      launch(W'(9));
      cyc = 0;
      while (n_dbl == 0 && cyc < 50) begin @(posedge clk); cyc++; end
      chk("first_dbl_seen", W'(n_dbl), W'(1));
      repeat (2) @(posedge clk);
      #1 reset = 1; in_op = 0;
      repeat (2) @(posedge clk);
      #1 reset = 0; inject_dbl = 1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #1;
         check_all_zero("after_reset");
      end
      launch(W'(2)); wait_done(500, cyc);

`ifdef SMUL_TIMEOUT_EN
      eng_on = 0;
      launch(W'(9));
      exp_mult = 0; exp_err = 1; exp_nd = 1; exp_na = 0;
      wait_done(100, cyc);
      chk("timeout_latency", W'(cyc >= 20 && cyc <= 30), W'(1));
      eng_on = 1;
`endif

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
